// File: rtl/loop_unwind_pkg.sv
// Shared constants and types for the loop unwinder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package loop_unwind_pkg;

  // Default datapath width for x, y, i and n.
  localparam int LU_W = 11;

  // Control states of the unwinder.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Reverse-step amounts: selector=1 removes (1,2), selector=0 removes (2,1).
  localparam int SEL1_DX = 1;
  localparam int SEL1_DY = 2;
  localparam int SEL0_DX = 2;
  localparam int SEL0_DY = 1;

endpackage

// File: rtl/loop_unwind_if.sv
// Load / status / ack bundle between a job producer and the unwinder.
// Latency: n/a (wiring only).
// Backpressure: load accepted only while load_ready; done held until done_ack.
interface loop_unwind_if
  import loop_unwind_pkg::*;
#(
  parameter int W = LU_W
);

  logic         selector;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] load_x;
  logic [W-1:0] load_y;
  logic [W-1:0] load_n;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic [W-1:0] i;
  logic [W-1:0] n;
  logic         busy;
  logic         done;
  logic         done_ack;
  logic         err;
  logic         bad_load;

  // Job producer side.
  modport master (
    output selector, load_valid, load_x, load_y, load_n, done_ack,
    input  load_ready, x, y, i, n, busy, done, err, bad_load
  );

  // Unwinder side.
  modport slave (
    input  selector, load_valid, load_x, load_y, load_n, done_ack,
    output load_ready, x, y, i, n, busy, done, err, bad_load
  );

endinterface

// File: rtl/loop_unwind_step.sv
// One reverse step: picks (dx,dy) from selector, forms x-dx / y-dy, flags underflow.
// Latency: combinational.
// Backpressure: none; the caller decides whether to commit the result.
module loop_unwind_step
  import loop_unwind_pkg::*;
#(
  parameter int W = LU_W
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         selector,
  output logic [W-1:0] dx,
  output logic [W-1:0] dy,
  output logic [W-1:0] x_next,
  output logic [W-1:0] y_next,
  output logic         underflow
);

  // Step amount select, subtraction and underflow detect.
  always_comb begin
    dx        = selector ? W'(SEL1_DX) : W'(SEL0_DX);
    dy        = selector ? W'(SEL1_DY) : W'(SEL0_DY);
    underflow = (x < dx) || (y < dy);
    x_next    = x - dx;
    y_next    = y - dy;
  end

endmodule

// File: rtl/loop_unwind.sv
// Unwinds a forward-loop (x,y,n) result back to zero, checking x+y == 3n on load.
// Latency: n cycles from load accept to done (done right after accept when n==0).
// Backpressure: load_ready only in IDLE; done holds until done_ack.
module loop_unwind
  import loop_unwind_pkg::*;
#(
  parameter int W = LU_W
) (
  input  logic           clk,
  input  logic           rst,
  loop_unwind_if.slave   bus
);

  state_t       state;
  logic [W-1:0] x_q;
  logic [W-1:0] y_q;
  logic [W-1:0] i_q;
  logic [W-1:0] n_q;
  logic         err_q;
  logic         bad_load_q;
  logic         busy_q;
  logic         done_q;
  logic         load_ready_q;

  logic [W-1:0] step_dx;
  logic [W-1:0] step_dy;
  logic [W-1:0] x_next;
  logic [W-1:0] y_next;
  logic         underflow;

  // Invariant operands are widened so neither the sum nor 3n can wrap.
  logic [W:0]   load_sum;
  logic [W+1:0] load_3n;
  logic         load_bad;

  // The step amounts themselves are only of interest inside the step block.
  logic         unused_step;

  loop_unwind_step #(.W(W)) u_step (
    .x         (x_q),
    .y         (y_q),
    .selector  (bus.selector),
    .dx        (step_dx),
    .dy        (step_dy),
    .x_next    (x_next),
    .y_next    (y_next),
    .underflow (underflow)
  );

  assign unused_step = ^{step_dx, step_dy};

  // Load-time invariant check: x+y against 3n, both zero-extended to W+2 bits.
  always_comb begin
    load_sum = {1'b0, bus.load_x} + {1'b0, bus.load_y};
    load_3n  = {2'b00, bus.load_n} + {1'b0, bus.load_n, 1'b0};
    load_bad = ({1'b0, load_sum} != load_3n);
  end

  // Control FSM with working registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      i_q          <= '0;
      n_q          <= '0;
      err_q        <= 1'b0;
      bad_load_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.load_valid) begin
            x_q          <= bus.load_x;
            y_q          <= bus.load_y;
            n_q          <= bus.load_n;
            i_q          <= bus.load_n;
            err_q        <= 1'b0;
            bad_load_q   <= load_bad;
            load_ready_q <= 1'b0;
            if (bus.load_n != '0) begin
              state  <= RUN;
              busy_q <= 1'b1;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end

        RUN: begin
          if (underflow) begin
            // Keep the pre-step values so the failing point is observable.
            err_q  <= 1'b1;
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            x_q <= x_next;
            y_q <= y_next;
            i_q <= i_q - W'(1);
            if (i_q == W'(1)) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end

        DONE: begin
          // err and bad_load stay visible until the next job is loaded.
          if (bus.done_ack) begin
            state        <= IDLE;
            done_q       <= 1'b0;
            load_ready_q <= 1'b1;
          end
        end

        default: begin
          state        <= IDLE;
          busy_q       <= 1'b0;
          done_q       <= 1'b0;
          load_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.i          = i_q;
  assign bus.n          = n_q;
  assign bus.err        = err_q;
  assign bus.bad_load   = bad_load_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.load_ready = load_ready_q;

endmodule

// File: tb/tb_loop_unwind.sv
// Directed-vector bench for loop_unwind with a queue-based done scoreboard.
// Latency: checks busy-cycle count per job against the expected step count.
// Backpressure: waits on load_ready before loading and acks every done.
module tb_loop_unwind;

  localparam int W = 11;

  logic clk;
  logic rst;

  loop_unwind_if #(.W(W)) bus ();

  loop_unwind #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int x;
    int y;
    int i;
    int n;
    int err;
    int bad;
    int steps;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int errors   = 0;
  int sel_mode = 0;   // 0/1: hold selector, 2: toggle every cycle
  int busy_cnt = 0;
  bit done_seen = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Selector driver for the alternating-pattern job.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sel_mode == 2) bus.selector = ~bus.selector;
    end
  end

  // Monitor: invariant every RUN cycle for clean jobs, scoreboard pop on done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt  = 0;
        done_seen = 0;
      end else begin
        if (bus.busy) begin
          busy_cnt++;
          if (exp_q.size() > 0 && exp_q[0].bad == 0)
            chk("run_invariant", int'(bus.x) + int'(bus.y), 3 * int'(bus.i));
        end
        if (bus.done && !done_seen) begin
          done_seen = 1;
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("done_x",     int'(bus.x),      e.x);
            chk("done_y",     int'(bus.y),      e.y);
            chk("done_i",     int'(bus.i),      e.i);
            chk("done_n",     int'(bus.n),      e.n);
            chk("done_err",   int'(bus.err),    e.err);
            chk("done_bad",   int'(bus.bad_load), e.bad);
            chk("done_steps", busy_cnt,         e.steps);
          end
          busy_cnt = 0;
        end
        if (!bus.done) done_seen = 0;
      end
    end
  end

  task automatic do_load(input int lx, input int ly, input int ln,
                         input int ex, input int ey, input int ei, input int eerr,
                         input int ebad, input int esteps, input bit push);
    int t;
    exp_t e;
    t = 0;
    while (!bus.load_ready && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!bus.load_ready) chk("load_ready_timeout", 0, 1);
    bus.load_x     = W'(lx);
    bus.load_y     = W'(ly);
    bus.load_n     = W'(ln);
    bus.load_valid = 1'b1;
    if (push) begin
      e.x = ex; e.y = ey; e.i = ei; e.n = ln;
      e.err = eerr; e.bad = ebad; e.steps = esteps;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.load_valid = 1'b0;
  endtask

  task automatic wait_done_ack();
    int t;
    t = 0;
    while (!bus.done && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!bus.done) chk("done_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.done_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.done_ack = 1'b0;
    chk("ack_load_ready", int'(bus.load_ready), 1);
    chk("ack_done_low",   int'(bus.done),       0);
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus.
  initial begin
    rst            = 1'b1;
    bus.selector   = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_x     = '0;
    bus.load_y     = '0;
    bus.load_n     = '0;
    bus.done_ack   = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    chk("rst_x",          int'(bus.x),          0);
    chk("rst_y",          int'(bus.y),          0);
    chk("rst_i",          int'(bus.i),          0);
    chk("rst_n",          int'(bus.n),          0);
    chk("rst_err",        int'(bus.err),        0);
    chk("rst_bad",        int'(bus.bad_load),   0);
    chk("rst_busy",       int'(bus.busy),       0);
    chk("rst_done",       int'(bus.done),       0);
    chk("rst_load_ready", int'(bus.load_ready), 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a job discards it.
    sel_mode = 1; bus.selector = 1'b1;
    do_load(40, 80, 40, 0, 0, 0, 0, 0, 0, 1'b0);
    repeat (10) begin @(posedge clk); #1; end
    chk("midrun_busy", int'(bus.busy), 1);
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("midrst_x",          int'(bus.x),          0);
    chk("midrst_y",          int'(bus.y),          0);
    chk("midrst_i",          int'(bus.i),          0);
    chk("midrst_n",          int'(bus.n),          0);
    chk("midrst_busy",       int'(bus.busy),       0);
    chk("midrst_done",       int'(bus.done),       0);
    chk("midrst_load_ready", int'(bus.load_ready), 1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("postrst_load_ready", int'(bus.load_ready), 1);
    chk("postrst_busy",       int'(bus.busy),       0);

    // Constant selector=1: 40 steps of (1,2) from (40,80).
    sel_mode = 1; bus.selector = 1'b1;
    do_load(40, 80, 40, 0, 0, 0, 0, 0, 40, 1'b1);
    wait_done_ack();

    // Alternating selector: 20 steps of each kind from (60,60).
    sel_mode = 2; bus.selector = 1'b1;
    do_load(60, 60, 40, 0, 0, 0, 0, 0, 40, 1'b1);
    wait_done_ack();

    // selector=0 on (1,5): x<2 underflows on the first RUN cycle.
    sel_mode = 0; bus.selector = 1'b0;
    do_load(1, 5, 2, 1, 5, 2, 1, 0, 1, 1'b1);
    wait_done_ack();

    // 10+10 != 15: bad_load flagged, unwinding continues to (5,0,0).
    sel_mode = 1; bus.selector = 1'b1;
    do_load(10, 10, 5, 5, 0, 0, 0, 1, 5, 1'b1);
    bus.load_x = W'(999); bus.load_y = W'(999); bus.load_n = W'(7);
    bus.load_valid = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    bus.load_valid = 1'b0;
    chk("bad_load_live", int'(bus.bad_load), 1);
    wait_done_ack();

    // n==0: done right after the accept edge.
    sel_mode = 0; bus.selector = 1'b0;
    do_load(0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
    chk("n0_done_immediate", int'(bus.done), 1);
    chk("n0_busy",           int'(bus.busy), 0);
    wait_done_ack();

    repeat (3) begin @(posedge clk); #1; end
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
